digit_serial_eq_ctrl: RTL

- Sequencing controller that computes WIDTH-bit equality over several cycles, reusing one 2-bit equality comparator slice.
- Operands arrive on a valid/ready input port. The controller walks 2-bit digits LSB-first, one per cycle, accumulating the result and optionally stopping at the first mismatch.
- The result leaves on a valid/ready output port. It serves area-constrained paths that trade latency for a single comparator slice.

---
 rtl/digit_serial_eq_ctrl_pkg.sv | 17 +
 rtl/digit_serial_eq_ctrl_comparator_2.sv | 12 +
 rtl/digit_serial_eq_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/digit_serial_eq_ctrl_pkg.sv
// Shared definitions for the digit-serial equality controller.
//   state_t  : controller FSM state encoding (IDLE, CMP, DONE)
//   calc_cw  : width of the digit-count output for a given operand width
package digit_serial_eq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Enough bits to hold a count of 1..WIDTH/2 digits.
  function automatic int calc_cw(input int width);
    return $clog2(width / 2 + 1);
  endfunction

endpackage

// File: rtl/digit_serial_eq_ctrl_comparator_2.sv
// comparator_2: single 2-bit equality comparator slice.
//   a, b : 2-bit digits to compare
//   eq   : 1 when a == b
module comparator_2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq
);

  assign eq = (a == b);

endmodule

// File: rtl/digit_serial_eq_ctrl.sv
// digit_serial_eq_ctrl: WIDTH-bit equality computed one 2-bit digit per
// cycle (LSB first) on a single shared comparator slice.
//   Clk_CI       clock, rising edge
//   Rst_SI       synchronous active-high reset
//   InValid_SI   operand pair valid
//   InReady_SO   controller can accept operands (IDLE only)
//   A_DI, B_DI   operands, captured on the input handshake
//   OutValid_SO  result valid (DONE)
//   OutReady_SI  consumer accepts result
//   Equal_DO     1 when A == B (for EARLY_EXIT=1, 0 on the first mismatch)
//   Cycles_DO    number of digits compared, 1..NDIG
//   Busy_SO      high while in CMP or DONE
module digit_serial_eq_ctrl
  import digit_serial_eq_ctrl_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int EARLY_EXIT = 1,
  localparam int NDIG       = WIDTH / 2,
  localparam int CW         = calc_cw(WIDTH)
) (
  input  logic          Clk_CI,
  input  logic          Rst_SI,
  input  logic          InValid_SI,
  output logic          InReady_SO,
  input  logic [WIDTH-1:0] A_DI,
  input  logic [WIDTH-1:0] B_DI,
  output logic          OutValid_SO,
  input  logic          OutReady_SI,
  output logic          Equal_DO,
  output logic [CW-1:0] Cycles_DO,
  output logic          Busy_SO
);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("digit_serial_eq_ctrl: WIDTH must be even and >= 2");
  end

  state_t           state_r, state_d;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CW-1:0]    cnt_r;
  logic             eq_acc_r;
  logic             equal_r;
  logic [CW-1:0]    cycles_r;

  logic [1:0]       a_dig, b_dig;
  logic             slice_eq;
  logic             last_dig;
  logic             cmp_exit;

  // Digit select: route the cnt-th 2-bit digit of each operand to the slice.
  always_comb begin
    a_dig = 2'b00;
    b_dig = 2'b00;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt_r == CW'(i)) begin
        a_dig = a_r[2*i +: 2];
        b_dig = b_r[2*i +: 2];
      end
    end
  end

  comparator_2 u_cmp (
    .a  (a_dig),
    .b  (b_dig),
    .eq (slice_eq)
  );

  assign last_dig = (cnt_r == CW'(NDIG - 1));
  assign cmp_exit = last_dig || ((EARLY_EXIT != 0) && !slice_eq);

  always_comb begin
    state_d = state_r;
    case (state_r)
      IDLE:    if (InValid_SI) state_d = CMP;
      CMP:     if (cmp_exit) state_d = DONE;
      DONE:    if (OutReady_SI) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage boundary: FSM, operand capture, digit counter and accumulator.
  always_ff @(posedge Clk_CI) begin
    if (Rst_SI) begin
      state_r  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      cnt_r    <= '0;
      eq_acc_r <= 1'b0;
      equal_r  <= 1'b0;
      cycles_r <= '0;
    end else begin
      state_r <= state_d;
      case (state_r)
        IDLE: begin
          if (InValid_SI) begin
            a_r      <= A_DI;
            b_r      <= B_DI;
            cnt_r    <= '0;
            eq_acc_r <= 1'b1;
          end
        end
        CMP: begin
          eq_acc_r <= eq_acc_r & slice_eq;
          if (cmp_exit) begin
            // Counter holds on exit so it never leaves 0..NDIG-1.
            equal_r  <= eq_acc_r & slice_eq;
            cycles_r <= cnt_r + CW'(1);
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign InReady_SO  = (state_r == IDLE) && !Rst_SI;
  assign OutValid_SO = (state_r == DONE);
  assign Busy_SO     = (state_r != IDLE);
  assign Equal_DO    = equal_r;
  assign Cycles_DO   = cycles_r;

endmodule
